scaler_out_packer: RTL and testbench
====================================

SCALER_OUT_PACKER -- requirements
Module: scaler_out_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per gray pixel.
REQ-002 SHALL have parameter PIX_PER_WORD, default 4, pixels packed per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output word FIFO capacity (power of two).
REQ-004 SHALL have port clk_i  input  1  single clock for all logic.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port tvalid_i  input  1  scaled pixel valid from the bilinear stage; no backpressure exists on this input.
REQ-007 SHALL have port tdata_i  input  DATA_WIDTH  scaled gray pixel.
REQ-008 SHALL have port dest_width_i  input  16  scaled frame width in pixels.
REQ-009 SHALL have port dest_height_i  input  16  scaled frame height in lines.
REQ-010 SHALL have port m_tvalid_o  output  1  output word valid.
REQ-011 SHALL have port m_tready_i  input  1  downstream ready.
REQ-012 SHALL have port m_tdata_o  output  DATA_WIDTH*PIX_PER_WORD  packed word.
REQ-013 SHALL have port m_tlast_o  output  1  word holds last pixel of a line.
REQ-014 SHALL have port m_tuser_o  output  1  word holds first pixel of a frame.
REQ-015 SHALL have port overflow_o  output  1  sticky word-dropped flag.
REQ-016 SHALL have port frame_done_o  output  1  one-cycle pulse at end of frame.

Function
REQ-017 SHALL keep x (0..W-1) and y (0..H-1) counters advanced once per cycle with tvalid_i=1; x wraps to 0 and y increments at x=W-1; y wraps to 0 after the last pixel of line H-1.
REQ-018 SHALL latch W/H from dest_width_i/dest_height_i when a pixel is accepted with x=0,y=0; mid-frame input changes SHALL have no effect until the next frame.
REQ-019 SHALL ignore all tvalid_i (no words, no counter change) while the latched or live W or H is 0.
REQ-020 SHALL pack pixels little-endian: first pixel of a word in bits [DATA_WIDTH-1:0].
REQ-021 SHALL emit a word when PIX_PER_WORD pixels are collected or when the last pixel of a line arrives; unfilled upper lanes of a partial word SHALL be zero; a new line always starts a new word.
REQ-022 SHALL set tlast on the word containing pixel x=W-1 and tuser on the word containing pixel x=0,y=0.
REQ-023 SHALL write the completed word (with tuser/tlast) into the FIFO on the clock edge after the edge sampling its final pixel.
REQ-024 SHALL present FIFO head as first-word-fall-through registered output; with empty FIFO, m_tvalid_o SHALL rise one edge after the write (two edges after the final pixel is sampled).
REQ-025 SHALL pop the head on any edge where m_tvalid_o=1 and m_tready_i=1; m_tdata_o/m_tlast_o/m_tuser_o SHALL hold stable while m_tvalid_o=1 and m_tready_i=0.
REQ-026 SHALL accept a write when occupancy < FIFO_DEPTH, or when full and a pop occurs on the same edge.
REQ-027 SHALL drop a word written when full without a same-edge pop, set overflow_o=1 and keep it until reset; pixel counters continue unaffected.
REQ-028 SHALL pulse frame_done_o high for exactly one cycle, on the cycle after the pixel at x=W-1,y=H-1 is sampled.

Reset
REQ-029 SHALL, while rst_i=0, force m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, overflow_o, frame_done_o to 0, empty the FIFO, clear x, y, packing state, and latched W/H.
REQ-030 SHALL, on reset mid-frame, discard the partial word and FIFO contents; the first pixel after release is treated as x=0,y=0.

Verification
REQ-031 Reset: rst_i=0 with tvalid_i toggling -> all outputs 0; after release first word carries tuser=1.
REQ-032 W=8,H=2, pixels 0x00..0x0F, m_tready_i=1 -> words 0x03020100(tuser=1), 0x07060504(tlast), 0x0B0A0908, 0x0F0E0D0C(tlast); one frame_done_o pulse after pixel 0x0F.
REQ-033 W=6,H=1, pixels 0x00..0x05 -> 0x03020100(tuser), 0x00000504(tlast).
REQ-034 W=68,H=1, m_tready_i=0 -> 16 words stored, 17th dropped, overflow_o=1; then m_tready_i=1 -> exactly 16 words out, last without tlast.
REQ-035 FIFO full, m_tready_i=1 on the edge a new word is written -> no drop, overflow_o stays 0, occupancy remains 16.
REQ-036 Change dest_width_i from 8 to 4 mid-frame -> current frame completes with W=8; next frame uses W=4.

Source files
------------

// File: rtl/scaler_out_packer.sv
// Packs scaled gray pixels into words and buffers them in a FWFT output FIFO.
// Ports: clk_i/rst_i (async active-low), tvalid_i/tdata_i pixel stream,
//        dest_width_i/dest_height_i frame size, m_* AXI-Stream style word
//        output (tuser = frame start, tlast = line end), overflow_o sticky
//        drop flag, frame_done_o one-cycle end-of-frame pulse.
module scaler_out_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               tvalid_i,
    input  logic [DATA_WIDTH-1:0]              tdata_i,
    input  logic [15:0]                        dest_width_i,
    input  logic [15:0]                        dest_height_i,
    output logic                               m_tvalid_o,
    input  logic                               m_tready_i,
    output logic [DATA_WIDTH*PIX_PER_WORD-1:0] m_tdata_o,
    output logic                               m_tlast_o,
    output logic                               m_tuser_o,
    output logic                               overflow_o,
    output logic                               frame_done_o
);

    localparam int WW = DATA_WIDTH * PIX_PER_WORD;
    localparam int LW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(PIX_PER_WORD - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    logic [15:0]   x_q, y_q, w_q, h_q;
    logic [15:0]   eff_w, eff_h;
    logic          frame_start, accept, last_x, last_y, word_done;
    logic [LW-1:0] lane_q;
    logic [WW-1:0] pack_q, pack_next;
    logic          user_q;

    logic          stage_valid_q, stage_last_q, stage_user_q;
    logic [WW-1:0] stage_data_q;

    logic [WW+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] mem_cnt_q, occ;
    logic          out_valid_q, out_last_q, out_user_q;
    logic [WW-1:0] out_data_q;
    logic          overflow_q, frame_done_q;
    logic          pop, load, wr;

    // At the top-left pixel the live size applies (and gets latched);
    // everywhere else the latched size of the current frame is used.
    always_comb begin
        frame_start = (x_q == 16'd0) && (y_q == 16'd0);
        eff_w       = frame_start ? dest_width_i  : w_q;
        eff_h       = frame_start ? dest_height_i : h_q;
        accept      = tvalid_i && (eff_w != 16'd0) && (eff_h != 16'd0);
        last_x      = (x_q == eff_w - 16'd1);
        last_y      = (y_q == eff_h - 16'd1);
        word_done   = (lane_q == LANE_MAX) || last_x;
        pack_next   = pack_q;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (lane_q == LW'(i)) begin
                pack_next[i*DATA_WIDTH +: DATA_WIDTH] = tdata_i;
            end
        end
    end

    // Occupancy counts the word held in the output register as well.
    always_comb begin
        occ  = mem_cnt_q + CW'(out_valid_q);
        pop  = out_valid_q && m_tready_i;
        load = (mem_cnt_q != '0) && (!out_valid_q || pop);
        wr   = stage_valid_q && ((occ < DEPTH_C) || pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            h_q           <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            user_q        <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_last_q  <= 1'b0;
            stage_user_q  <= 1'b0;
            stage_data_q  <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            stage_valid_q <= accept && word_done;
            frame_done_q  <= accept && last_x && last_y;
            if (accept) begin
                if (frame_start) begin
                    w_q <= dest_width_i;
                    h_q <= dest_height_i;
                end
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? 16'd0 : y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
                if (word_done) begin
                    lane_q       <= '0;
                    pack_q       <= '0;
                    user_q       <= 1'b0;
                    stage_data_q <= pack_next;
                    stage_last_q <= last_x;
                    stage_user_q <= user_q | frame_start;
                end else begin
                    lane_q <= lane_q + LW'(1);
                    pack_q <= pack_next;
                    user_q <= user_q | frame_start;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= {stage_user_q, stage_last_q, stage_data_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_q + CW'(wr) - CW'(load);
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                out_valid_q <= 1'b1;
                {out_user_q, out_last_q, out_data_q} <= mem_q[rd_ptr_q];
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            if (stage_valid_q && !wr) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign m_tvalid_o   = out_valid_q;
    assign m_tdata_o    = out_data_q;
    assign m_tlast_o    = out_last_q;
    assign m_tuser_o    = out_user_q;
    assign overflow_o   = overflow_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_scaler_out_packer.sv
// Directed bench for scaler_out_packer: table of expected words plus
// hand sequences for reset, output latency, overflow and full-with-pop.
module tb_scaler_out_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tvalid_i;
    logic [7:0]  tdata_i;
    logic [15:0] dest_width_i;
    logic [15:0] dest_height_i;
    logic        m_tvalid_o;
    logic        m_tready_i;
    logic [31:0] m_tdata_o;
    logic        m_tlast_o;
    logic        m_tuser_o;
    logic        overflow_o;
    logic        frame_done_o;

    scaler_out_packer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tvalid_i      (tvalid_i),
        .tdata_i       (tdata_i),
        .dest_width_i  (dest_width_i),
        .dest_height_i (dest_height_i),
        .m_tvalid_o    (m_tvalid_o),
        .m_tready_i    (m_tready_i),
        .m_tdata_o     (m_tdata_o),
        .m_tlast_o     (m_tlast_o),
        .m_tuser_o     (m_tuser_o),
        .overflow_o    (overflow_o),
        .frame_done_o  (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } word_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] data;
        logic        last;
        logic        user;
    } vec_t;

    localparam int NV = 11;
    vec_t  vec [NV];
    word_t cap_q [$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    fd_cnt = 0;
    logic [33:0] snap;

    always @(negedge clk_i) begin
        if (rst_i && m_tvalid_o && m_tready_i)
            cap_q.push_back('{d: m_tdata_o, l: m_tlast_o, u: m_tuser_o});
        if (frame_done_o)
            fd_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [7:0] d);
        tvalid_i = 1'b1;
        tdata_i  = d;
        @(posedge clk_i);
        #1;
        tvalid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while (cap_q.size() < n && k < 300) begin
            @(posedge clk_i);
            k++;
        end
        #1;
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o,
                         overflow_o, frame_done_o}), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0]  = '{16'd8, 16'd2, 32'h03020100, 1'b0, 1'b1};
        vec[1]  = '{16'd8, 16'd2, 32'h07060504, 1'b1, 1'b0};
        vec[2]  = '{16'd8, 16'd2, 32'h0B0A0908, 1'b0, 1'b0};
        vec[3]  = '{16'd8, 16'd2, 32'h0F0E0D0C, 1'b1, 1'b0};
        vec[4]  = '{16'd6, 16'd1, 32'h03020100, 1'b0, 1'b1};
        vec[5]  = '{16'd6, 16'd1, 32'h00000504, 1'b1, 1'b0};
        vec[6]  = '{16'd8, 16'd1, 32'h03020100, 1'b0, 1'b1};
        vec[7]  = '{16'd8, 16'd1, 32'h07060504, 1'b1, 1'b0};
        vec[8]  = '{16'd4, 16'd1, 32'h13121110, 1'b1, 1'b1};
        vec[9]  = '{16'd2, 16'd1, 32'h0000BBAA, 1'b1, 1'b1};
        vec[10] = '{16'd0, 16'd0, 32'h0, 1'b0, 1'b0};
        vec[10] = vec[9];
        vec[10].w = 16'd2;

        rst_i         = 1'b0;
        tvalid_i      = 1'b0;
        tdata_i       = 8'h00;
        m_tready_i    = 1'b1;
        dest_width_i  = 16'd8;
        dest_height_i = 16'd2;

        // reset held while pixels toggle
        for (int i = 0; i < 4; i++) begin
            tvalid_i = i[0];
            tdata_i  = 8'(i + 8'h70);
            @(posedge clk_i);
            #1;
            check_zero("reset_outputs");
        end
        tvalid_i = 1'b0;
        rst_i    = 1'b1;
        idle(2);

        // W=8 H=2
        for (int i = 0; i < 16; i++) pix(8'(i));
        check("frame_done_pulse", 64'(frame_done_o), 64'd1);
        idle(1);
        check("frame_done_single", 64'(frame_done_o), 64'd0);
        idle(6);

        // W=6 H=1, with output latency check on the first word
        dest_width_i  = 16'd6;
        dest_height_i = 16'd1;
        for (int i = 0; i < 4; i++) pix(8'(i));
        check("latency_e0", 64'(m_tvalid_o), 64'd0);
        idle(1);
        check("latency_e1", 64'(m_tvalid_o), 64'd0);
        idle(1);
        check("latency_e2", 64'(m_tvalid_o), 64'd1);
        pix(8'h04);
        pix(8'h05);
        idle(6);

        // W=8 H=1 with width changed to 4 mid-frame
        dest_width_i = 16'd8;
        for (int i = 0; i < 4; i++) pix(8'(i));
        dest_width_i = 16'd4;
        for (int i = 4; i < 8; i++) pix(8'(i));
        for (int i = 0; i < 4; i++) pix(8'(8'h10 + i));
        idle(6);

        // zero width, then zero height are ignored
        dest_width_i = 16'd0;
        for (int i = 0; i < 3; i++) pix(8'h55);
        dest_width_i  = 16'd2;
        dest_height_i = 16'd0;
        for (int i = 0; i < 3; i++) pix(8'h66);
        idle(4);
        check("zero_dims_no_words", 64'(cap_q.size()), 64'd9);
        dest_height_i = 16'd1;
        pix(8'hAA);
        pix(8'hBB);
        wait_words(10);
        idle(4);
        check("frame_done_count", 64'(fd_cnt), 64'd5);
        check("word_count", 64'(cap_q.size()), 64'd10);

        for (int i = 0; i < NV - 1; i++) begin
            n_vec++;
            if (i >= cap_q.size()) begin
                n_bad++;
                $display("FAIL vec%0d: no word captured, expected data=%h",
                         i, vec[i].data);
            end else if (cap_q[i].d !== vec[i].data ||
                         cap_q[i].l !== vec[i].last ||
                         cap_q[i].u !== vec[i].user) begin
                n_bad++;
                $display("FAIL vec%0d W=%0d H=%0d: got data=%h last=%b user=%b expected data=%h last=%b user=%b",
                         i, vec[i].w, vec[i].h, cap_q[i].d, cap_q[i].l,
                         cap_q[i].u, vec[i].data, vec[i].last, vec[i].user);
            end
        end

        // overflow: W=68 H=1 with ready low
        cap_q.delete();
        m_tready_i    = 1'b0;
        dest_width_i  = 16'd68;
        dest_height_i = 16'd1;
        for (int i = 0; i < 68; i++) pix(8'(i));
        idle(6);
        check("overflow_set", 64'(overflow_o), 64'd1);
        check("ovf_head_valid", 64'(m_tvalid_o), 64'd1);
        snap = {m_tuser_o, m_tlast_o, m_tdata_o};
        check("ovf_head_word", 64'(snap), 64'({1'b1, 1'b0, 32'h03020100}));
        idle(3);
        check("hold_stable", 64'({m_tuser_o, m_tlast_o, m_tdata_o}), 64'(snap));
        m_tready_i = 1'b1;
        wait_words(16);
        idle(6);
        check("ovf_drain_count", 64'(cap_q.size()), 64'd16);
        if (cap_q.size() > 0)
            check("ovf_last_word",
                  64'({cap_q[cap_q.size()-1].l, cap_q[cap_q.size()-1].d}),
                  64'({1'b0, 32'h3F3E3D3C}));
        check("overflow_sticky", 64'(overflow_o), 64'd1);
        check("drained_empty", 64'(m_tvalid_o), 64'd0);

        rst_i = 1'b0;
        #1;
        check_zero("reset_clears_overflow");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        idle(1);

        // full FIFO with a pop on the write edge
        cap_q.delete();
        m_tready_i   = 1'b0;
        dest_width_i = 16'd64;
        for (int i = 0; i < 64; i++) pix(8'(i));
        idle(5);
        check("full_no_overflow", 64'(overflow_o), 64'd0);
        dest_width_i = 16'd4;
        for (int i = 0; i < 4; i++) pix(8'(8'h40 + i));
        m_tready_i = 1'b1;
        @(posedge clk_i);
        #1;
        m_tready_i = 1'b0;
        idle(3);
        check("full_pop_no_drop", 64'(overflow_o), 64'd0);
        check("full_pop_one_out", 64'(cap_q.size()), 64'd1);
        m_tready_i = 1'b1;
        wait_words(17);
        idle(4);
        check("full_pop_total", 64'(cap_q.size()), 64'd17);
        if (cap_q.size() > 1)
            check("full_pop_second", 64'(cap_q[1].d), 64'h07060504);
        if (cap_q.size() > 0)
            check("full_pop_newword",
                  64'({cap_q[cap_q.size()-1].u, cap_q[cap_q.size()-1].l,
                       cap_q[cap_q.size()-1].d}),
                  64'({1'b1, 1'b1, 32'h43424140}));

        // reset in the middle of a frame
        cap_q.delete();
        dest_width_i = 16'd8;
        pix(8'hE0);
        pix(8'hE1);
        pix(8'hE2);
        rst_i = 1'b0;
        #1;
        check_zero("midframe_reset");
        @(posedge clk_i);
        #1;
        rst_i        = 1'b1;
        dest_width_i = 16'd4;
        for (int i = 0; i < 4; i++) pix(8'(8'h20 + i));
        wait_words(1);
        idle(3);
        check("post_reset_count", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() > 0)
            check("post_reset_word",
                  64'({cap_q[0].u, cap_q[0].l, cap_q[0].d}),
                  64'({1'b1, 1'b1, 32'h23222120}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
